apb_i2c_regif: RTL and testbench

//  Next-generation APB3 register interface for the I2C controller. Parametrised data/prescale width,

---
 rtl/apb_i2c_pkg.sv | 21 ++
 rtl/apb_wait_ctrl.sv | 52 +++++
 rtl/apb_i2c_regif.sv | 162 ++++++++++++++++
 tb/tb_apb_i2c_regif.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB I2C register interface: register indices,
// access FSM states and command-register bit positions.
package apb_i2c_pkg;

  localparam logic [2:0] REG_TX         = 3'd0;
  localparam logic [2:0] REG_RX         = 3'd1;
  localparam logic [2:0] REG_STATUS     = 3'd2;
  localparam logic [2:0] REG_SLAVE_ADDR = 3'd3;
  localparam logic [2:0] REG_COMMAND    = 3'd4;
  localparam logic [2:0] REG_PRESCALE   = 3'd5;
  localparam logic [2:0] REG_IRQ_EN     = 3'd6;
  localparam logic [2:0] REG_IRQ_PEND   = 3'd7;

  localparam int CMD_START_BIT = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_wait_ctrl.sv
// APB setup/access sequencer with programmable wait states; complete_o marks
// the access-phase cycle in which the transfer finishes.
module apb_wait_ctrl
  import apb_i2c_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic pclk_i,
  input  logic preset_ni,
  input  logic psel_i,
  input  logic penable_i,
  output logic complete_o
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  apb_state_e state_q;
  logic [3:0] cnt_q;

  assign complete_o = (state_q == ST_ACCESS) && (cnt_q == WS) && psel_i && penable_i;

  // Access FSM; a dropped psel_i abandons the transfer without completion.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (psel_i && !penable_i) begin
            state_q <= ST_ACCESS;
            cnt_q   <= 4'd0;
          end
        end
        ST_ACCESS: begin
          if (!psel_i) begin
            state_q <= ST_IDLE;
          end else if (cnt_q < WS) begin
            cnt_q <= cnt_q + 4'd1;
          end else if (penable_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: rtl/apb_i2c_regif.sv
// APB3 register file for the I2C controller: decode, error response, FIFO strobes.
// Optional interrupt registers are built when APB_I2C_IRQ_EN is defined.
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int WAIT_STATES    = 0,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      pclk_i,
  input  logic                      preset_ni,
  input  logic [ADDR_WIDTH-1:0]     paddr_i,
  input  logic                      psel_i,
  input  logic                      penable_i,
  input  logic                      pwrite_i,
  input  logic [DATA_WIDTH-1:0]     pwdata_i,
  output logic [DATA_WIDTH-1:0]     prdata_o,
  output logic                      pready_o,
  output logic                      pslverr_o,
  input  logic [7:0]                status_i,
  input  logic                      tx_full_i,
  input  logic                      rx_empty_i,
  input  logic [7:0]                rx_data_i,
  output logic [7:0]                tx_data_o,
  output logic                      tx_push_o,
  output logic                      rx_pop_o,
  output logic [7:0]                slave_addr_o,
  output logic [7:0]                command_o,
  output logic [PRESCALE_WIDTH-1:0] prescale_o,
  output logic                      irq_o
);

  logic                      complete_s;
  logic [2:0]                idx_s;
  logic [DATA_WIDTH-1:0]     rd_val_s;
  logic                      err_s;
  logic                      wr_ok_s;
  logic                      rd_ok_s;
  logic                      unused_s;

  logic [7:0]                tx_data_q,  tx_data_d;
  logic [7:0]                slave_q,    slave_d;
  logic [7:0]                command_q,  command_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      tx_push_q,  tx_push_d;
  logic                      rx_pop_q,   rx_pop_d;

`ifdef APB_I2C_IRQ_EN
  logic [7:0] irq_en_q,   irq_en_d;
  logic [7:0] irq_pend_q, irq_pend_d;
  logic [7:0] status_prev_q;
  logic       irq_q;
`endif

  apb_wait_ctrl #(.WAIT_STATES(WAIT_STATES)) u_wait_ctrl (
    .pclk_i     (pclk_i),
    .preset_ni  (preset_ni),
    .psel_i     (psel_i),
    .penable_i  (penable_i),
    .complete_o (complete_s)
  );

  assign idx_s    = paddr_i[4:2];
  assign unused_s = ^{paddr_i, pwdata_i};

  // Address decode: read value and error classification for the current access.
  always_comb begin
    rd_val_s = '0;
    err_s    = 1'b0;
    case (idx_s)
      REG_TX:         if (pwrite_i) err_s = tx_full_i; else rd_val_s = DATA_WIDTH'(tx_data_q);
      REG_RX:         if (pwrite_i || rx_empty_i) err_s = 1'b1; else rd_val_s = DATA_WIDTH'(rx_data_i);
      REG_STATUS:     if (pwrite_i) err_s = 1'b1; else rd_val_s = DATA_WIDTH'(status_i);
      REG_SLAVE_ADDR: rd_val_s = DATA_WIDTH'(slave_q);
      REG_COMMAND:    rd_val_s = DATA_WIDTH'(command_q);
      REG_PRESCALE:   rd_val_s = DATA_WIDTH'(prescale_q);
`ifdef APB_I2C_IRQ_EN
      REG_IRQ_EN:     rd_val_s = DATA_WIDTH'(irq_en_q);
      REG_IRQ_PEND:   rd_val_s = DATA_WIDTH'(irq_pend_q);
`endif
      default:        err_s = 1'b1;
    endcase
  end

  assign wr_ok_s   = complete_s && pwrite_i && !err_s;
  assign rd_ok_s   = complete_s && !pwrite_i && !err_s;
  assign pready_o  = complete_s;
  assign pslverr_o = complete_s && err_s;
  assign prdata_o  = rd_ok_s ? rd_val_s : '0;

  // Next-state for the register file; START is forced low unless rewritten this cycle.
  always_comb begin
    tx_data_d  = (wr_ok_s && idx_s == REG_TX)         ? pwdata_i[7:0] : tx_data_q;
    slave_d    = (wr_ok_s && idx_s == REG_SLAVE_ADDR) ? pwdata_i[7:0] : slave_q;
    prescale_d = (wr_ok_s && idx_s == REG_PRESCALE)   ? pwdata_i[PRESCALE_WIDTH-1:0] : prescale_q;
    command_d  = command_q;
    command_d[CMD_START_BIT] = 1'b0;
    if (wr_ok_s && idx_s == REG_COMMAND) begin
      command_d = pwdata_i[7:0];
    end else begin
      command_d = command_d;
    end
    tx_push_d = wr_ok_s && (idx_s == REG_TX);
    rx_pop_d  = rd_ok_s && (idx_s == REG_RX);
  end

  // Register file and one-cycle FIFO strobes.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      tx_data_q  <= 8'd0;
      slave_q    <= 8'd0;
      command_q  <= 8'd0;
      prescale_q <= '0;
      tx_push_q  <= 1'b0;
      rx_pop_q   <= 1'b0;
    end else begin
      tx_data_q  <= tx_data_d;
      slave_q    <= slave_d;
      command_q  <= command_d;
      prescale_q <= prescale_d;
      tx_push_q  <= tx_push_d;
      rx_pop_q   <= rx_pop_d;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign slave_addr_o = slave_q;
  assign command_o    = command_q;
  assign prescale_o   = prescale_q;
  assign tx_push_o    = tx_push_q;
  assign rx_pop_o     = rx_pop_q;

`ifdef APB_I2C_IRQ_EN
  // Pending bits: a rising status edge outranks a simultaneous W1C.
  always_comb begin
    irq_en_d   = (wr_ok_s && idx_s == REG_IRQ_EN) ? pwdata_i[7:0] : irq_en_q;
    irq_pend_d = irq_pend_q & ~((wr_ok_s && idx_s == REG_IRQ_PEND) ? pwdata_i[7:0] : 8'd0);
    irq_pend_d = irq_pend_d | (status_i & ~status_prev_q);
  end

  // Interrupt state and registered request line.
  always_ff @(posedge pclk_i or negedge preset_ni) begin
    if (!preset_ni) begin
      irq_en_q      <= 8'd0;
      irq_pend_q    <= 8'd0;
      status_prev_q <= 8'd0;
      irq_q         <= 1'b0;
    end else begin
      irq_en_q      <= irq_en_d;
      irq_pend_q    <= irq_pend_d;
      status_prev_q <= status_i;
      irq_q         <= |(irq_pend_q & irq_en_q);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Scoreboard bench for apb_i2c_regif (WAIT_STATES=2): directed cases then random
// APB traffic checked against a rule-level register model.
module tb_apb_i2c_regif;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int WS = 2;
  localparam int PW = 16;

  logic          pclk = 1'b0;
  logic          preset_n = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [DW-1:0] prdata_o;
  logic          pready_o, pslverr_o;
  logic [7:0]    status = 8'd0, rx_data = 8'd0;
  logic          tx_full = 1'b0, rx_empty = 1'b0;
  logic [7:0]    tx_data_o, slave_addr_o, command_o;
  logic          tx_push_o, rx_pop_o, irq_o;
  logic [PW-1:0] prescale_o;

  apb_i2c_regif #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(WS), .PRESCALE_WIDTH(PW)) dut (
    .pclk_i(pclk), .preset_ni(preset_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o), .status_i(status), .tx_full_i(tx_full), .rx_empty_i(rx_empty),
    .rx_data_i(rx_data), .tx_data_o(tx_data_o), .tx_push_o(tx_push_o), .rx_pop_o(rx_pop_o),
    .slave_addr_o(slave_addr_o), .command_o(command_o), .prescale_o(prescale_o), .irq_o(irq_o)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [31:0] prdata;
    logic        err;
    logic        push;
    logic        pop;
    logic [7:0]  tx;
    logic [7:0]  sa;
    logic [7:0]  cmd;
    logic [15:0] pre;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0]  m_tx = 8'd0, m_sa = 8'd0, m_cmd = 8'd0;
  logic [15:0] m_pre = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One APB transfer; the expected response is derived from the register rules and queued.
  task automatic apb_xfer(input logic [2:0] idx, input logic wr, input logic [31:0] wd,
                          input logic full, input logic empty, input logic [7:0] rxd,
                          input logic [7:0] st);
    exp_t e;
    int   waits;
    bit   done;
    logic [2:0] hi;
    hi = 3'($urandom);
    @(posedge pclk); #1;
    paddr = {hi, idx, 2'b00}; pwrite = wr; pwdata = wd;
    tx_full = full; rx_empty = empty; rx_data = rxd; status = st;
    psel = 1'b1; penable = 1'b0;
    e = '0;
    e.tx = m_tx; e.sa = m_sa; e.cmd = m_cmd; e.pre = m_pre;
    case (idx)
      3'd0: if (wr) begin
              if (full) e.err = 1'b1; else begin e.tx = wd[7:0]; e.push = 1'b1; end
            end else e.prdata = {24'd0, m_tx};
      3'd1: if (wr || empty) e.err = 1'b1; else begin e.prdata = {24'd0, rxd}; e.pop = 1'b1; end
      3'd2: if (wr) e.err = 1'b1; else e.prdata = {24'd0, st};
      3'd3: if (wr) e.sa = wd[7:0]; else e.prdata = {24'd0, m_sa};
      3'd4: if (wr) e.cmd = wd[7:0]; else e.prdata = {24'd0, m_cmd};
      3'd5: if (wr) e.pre = wd[15:0]; else e.prdata = {16'd0, m_pre};
      default: e.err = 1'b1;
    endcase
    if (wr || e.err) e.prdata = 32'd0;
    m_tx = e.tx; m_sa = e.sa; m_pre = e.pre; m_cmd = {e.cmd[7:1], 1'b0};
    q.push_back(e);
    @(posedge pclk); #1;
    penable = 1'b1;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge pclk);
      if (pready_o) done = 1'b1; else waits++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL pready_timeout: got no pready_o, expected one within 40 cycles");
    end else begin
      check("wait_states", 32'(waits), 32'(WS));
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  exp_t post_e;
  bit   post_pending = 1'b0;
  bit   clr_pending  = 1'b0;

  // Monitor: pops on every completed transfer and checks the committed state one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge pclk);
      if (post_pending) begin
        check("tx_push", {31'd0, tx_push_o}, {31'd0, post_e.push});
        check("rx_pop",  {31'd0, rx_pop_o},  {31'd0, post_e.pop});
        check("tx_data",    {24'd0, tx_data_o},    {24'd0, post_e.tx});
        check("slave_addr", {24'd0, slave_addr_o}, {24'd0, post_e.sa});
        check("command",    {24'd0, command_o},    {24'd0, post_e.cmd});
        check("prescale",   {16'd0, prescale_o},   {16'd0, post_e.pre});
        clr_pending  = post_e.cmd[0];
        post_pending = 1'b0;
      end else begin
        if (clr_pending) begin
          check("start_clear", {24'd0, command_o}, {24'd0, post_e.cmd[7:1], 1'b0});
          clr_pending = 1'b0;
        end
        check("idle_strobes", {30'd0, tx_push_o, rx_pop_o}, 32'd0);
      end
      if (pready_o) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pready: got pready_o=1, expected no transfer pending");
        end else begin
          e = q.pop_front();
          check("prdata",  prdata_o, e.prdata);
          check("pslverr", {31'd0, pslverr_o}, {31'd0, e.err});
          post_e       = e;
          post_pending = 1'b1;
        end
      end else begin
        check("idle_resp", prdata_o | {31'd0, pslverr_o}, 32'd0);
      end
    end
  end

  initial begin
    repeat (3) @(posedge pclk);
    #1 preset_n = 1'b1;
    @(negedge pclk);
    check("rst_regs", {tx_data_o, slave_addr_o, command_o, 8'd0}, 32'd0);
    check("rst_pre",  {16'd0, prescale_o}, 32'd0);
    check("rst_out",  {28'd0, tx_push_o, rx_pop_o, irq_o, pready_o}, 32'd0);

    // Reset during the wait phase of a PRESCALE write must abort the commit.
    @(posedge pclk); #1;
    paddr = 8'h14; pwrite = 1'b1; pwdata = 32'h0000_BEEF; psel = 1'b1; penable = 1'b0;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk); #2;
    preset_n = 1'b0;
    #1;
    check("rst_mid_pready",   {31'd0, pready_o}, 32'd0);
    check("rst_mid_prescale", {16'd0, prescale_o}, 32'd0);
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    preset_n = 1'b1;
    repeat (3) @(negedge pclk);
    check("rst_mid_after", {16'd0, prescale_o}, 32'd0);

    apb_xfer(3'd3, 1'b1, 32'h0000_003C, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd0, 1'b1, 32'h0000_00A5, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd0, 1'b1, 32'h0000_0011, 1'b1, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd1, 1'b0, 32'h0,         1'b0, 1'b0, 8'h5A, 8'h00);
    apb_xfer(3'd1, 1'b0, 32'h0,         1'b0, 1'b1, 8'h77, 8'h00);
    apb_xfer(3'd4, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd2, 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 8'h00, 8'h81);
    apb_xfer(3'd2, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 8'h81);
    apb_xfer(3'd5, 1'b1, 32'hDEAD_1234, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd5, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 8'h00);
`ifndef APB_I2C_IRQ_EN
    apb_xfer(3'd6, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 8'h00, 8'h00);
    apb_xfer(3'd7, 1'b0, 32'h0,         1'b0, 1'b0, 8'h00, 8'h00);
`endif

    for (int n = 0; n < 150; n++) begin
      logic [2:0] idx;
`ifdef APB_I2C_IRQ_EN
      idx = 3'($urandom_range(0, 5));
`else
      idx = 3'($urandom_range(0, 7));
`endif
      apb_xfer(idx, 1'($urandom), $urandom, ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom));
    end

    repeat (4) @(negedge pclk);
    check("sb_drain", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
